// File: rtl/imm_gen_pkg.sv
// Shared types and constants for the decode-stage immediate generator.
package imm_gen_pkg;

    // Immediate format code carried alongside every decoded entry.
    typedef enum logic [2:0] {
        ImmR    = 3'd0,
        ImmI    = 3'd1,
        ImmS    = 3'd2,
        ImmB    = 3'd3,
        ImmU    = 3'd4,
        ImmJ    = 3'd5,
        ImmSh   = 3'd6,
        ImmNone = 3'd7
    } imm_fmt_e;

    // Base RV opcodes recognised by the decoder (inst[6:0]).
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    // OP-IMM funct3 values that select a shift (slli / srli / srai).
    function automatic logic is_shift_funct3(input logic [2:0] funct3);
        return (funct3 == 3'b001) || (funct3 == 3'b101);
    endfunction

endpackage

// File: rtl/imm_decode.sv
// Combinational instruction-format classifier and immediate extractor.
module imm_decode
    import imm_gen_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [31:0]     inst_i,
    output logic [XLEN-1:0] imm_o,
    output imm_fmt_e        fmt_o,
    output logic            illegal_o
);

    logic [6:0]  opcode;
    logic [31:0] imm32;
    logic [31:0] shamt32;
    logic        zext;

    assign opcode = inst_i[6:0];

    // RV64 shifts use a 6-bit shamt; funct7 bits above it never leak in.
    assign shamt32 = (XLEN == 64) ? {26'b0, inst_i[25:20]} : {27'b0, inst_i[24:20]};

    // Classify the opcode and assemble the raw 32-bit immediate.
    always_comb begin
        imm32     = '0;
        fmt_o     = ImmNone;
        illegal_o = 1'b0;
        zext      = 1'b0;
        unique case (opcode)
            OPC_LOAD, OPC_JALR: begin
                fmt_o = ImmI;
                imm32 = {{20{inst_i[31]}}, inst_i[31:20]};
            end
            OPC_OPIMM: begin
                if (is_shift_funct3(inst_i[14:12])) begin
                    fmt_o = ImmSh;
                    imm32 = shamt32;
                    zext  = 1'b1;
                end else begin
                    fmt_o = ImmI;
                    imm32 = {{20{inst_i[31]}}, inst_i[31:20]};
                end
            end
            OPC_STORE: begin
                fmt_o = ImmS;
                imm32 = {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
            end
            OPC_BRANCH: begin
                fmt_o = ImmB;
                imm32 = {{19{inst_i[31]}}, inst_i[31], inst_i[7], inst_i[30:25],
                         inst_i[11:8], 1'b0};
            end
            OPC_LUI, OPC_AUIPC: begin
                fmt_o = ImmU;
                imm32 = {inst_i[31:12], 12'b0};
            end
            OPC_JAL: begin
                fmt_o = ImmJ;
                imm32 = {{11{inst_i[31]}}, inst_i[31], inst_i[19:12], inst_i[20],
                         inst_i[30:21], 1'b0};
            end
            OPC_OP: begin
                fmt_o = ImmR;
            end
            default: begin
                illegal_o = 1'b1;
            end
        endcase
    end

    // Widen to XLEN; every non-shift immediate already carries inst[31] in bit 31.
    always_comb begin
        if (zext) begin
            imm_o = XLEN'(imm32);
        end else begin
            imm_o = XLEN'($signed(imm32));
        end
    end

endmodule

// File: rtl/imm_gen_pipe.sv
// Registered immediate generator: decode feeding a 2-entry skid buffer,
// plus a saturating count of illegal instructions handed downstream.
module imm_gen_pipe
    import imm_gen_pkg::*;
#(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned TAG_W = 5,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      inst_code,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  imm_out,
    output logic [2:0]       imm_fmt,
    output logic             imm_illegal,
    output logic [TAG_W-1:0] out_tag,
    output logic [CNT_W-1:0] illegal_cnt
);

    // Entry widths follow this instance's XLEN/TAG_W, so the type lives here.
    typedef struct packed {
        logic [XLEN-1:0]  imm;
        imm_fmt_e         fmt;
        logic             illegal;
        logic [TAG_W-1:0] tag;
    } imm_entry_t;

    imm_entry_t      dec_entry;
    imm_entry_t      main_q, main_d;
    imm_entry_t      skid_q, skid_d;
    logic            main_valid_q, main_valid_d;
    logic            skid_valid_q, skid_valid_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic            accept;
    logic            deliver;

    imm_decode #(
        .XLEN (XLEN)
    ) u_decode (
        .inst_i    (inst_code),
        .imm_o     (dec_entry.imm),
        .fmt_o     (dec_entry.fmt),
        .illegal_o (dec_entry.illegal)
    );

    assign dec_entry.tag = in_tag;

    assign in_ready = !skid_valid_q && !reset;
    assign accept   = in_valid && in_ready;
    assign deliver  = main_valid_q && out_ready;

    // Skid-buffer next state: main always holds the oldest entry.
    always_comb begin
        main_d       = main_q;
        main_valid_d = main_valid_q;
        skid_d       = skid_q;
        skid_valid_d = skid_valid_q;
        if (!main_valid_q) begin
            if (accept) begin
                main_d       = dec_entry;
                main_valid_d = 1'b1;
            end
        end else if (deliver) begin
            if (skid_valid_q) begin
                // in_ready is low while skid is full, so nothing is accepted here.
                main_d       = skid_q;
                skid_valid_d = 1'b0;
            end else if (accept) begin
                main_d = dec_entry;
            end else begin
                main_valid_d = 1'b0;
            end
        end else if (accept) begin
            skid_d       = dec_entry;
            skid_valid_d = 1'b1;
        end
    end

    // Saturating count of illegal entries actually handed downstream.
    always_comb begin
        cnt_d = cnt_q;
        if (deliver && main_q.illegal && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // State registers with synchronous reset; reset drops any in-flight entries.
    always_ff @(posedge clk) begin
        if (reset) begin
            main_q       <= '0;
            main_valid_q <= 1'b0;
            skid_q       <= '0;
            skid_valid_q <= 1'b0;
            cnt_q        <= '0;
        end else begin
            main_q       <= main_d;
            main_valid_q <= main_valid_d;
            skid_q       <= skid_d;
            skid_valid_q <= skid_valid_d;
            cnt_q        <= cnt_d;
        end
    end

    // Outputs come straight from the main entry.
    always_comb begin
        out_valid   = main_valid_q;
        imm_out     = main_q.imm;
        imm_fmt     = main_q.fmt;
        imm_illegal = main_q.illegal;
        out_tag     = main_q.tag;
        illegal_cnt = cnt_q;
    end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench for imm_gen_pipe: XLEN=32 reference, an XLEN=64 copy and a
// CNT_W=2 copy all driven by the same stimulus.
module tb_imm_gen_pipe;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic [31:0] inst_code;
    logic [4:0]  in_tag;
    logic        out_ready;

    logic        in_ready_a,  out_valid_a,  illegal_a;
    logic [31:0] imm_a;
    logic [2:0]  fmt_a;
    logic [4:0]  tag_a;
    logic [15:0] cnt_a;

    logic        in_ready_b,  out_valid_b,  illegal_b;
    logic [63:0] imm_b;
    logic [2:0]  fmt_b;
    logic [4:0]  tag_b;
    logic [15:0] cnt_b;

    logic        in_ready_c,  out_valid_c,  illegal_c;
    logic [31:0] imm_c;
    logic [2:0]  fmt_c;
    logic [4:0]  tag_c;
    logic [1:0]  cnt_c;

    int n_tests = 0;
    int n_fail  = 0;

    imm_gen_pipe #(.XLEN(32), .TAG_W(5), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_a),
        .inst_code(inst_code), .in_tag(in_tag), .out_valid(out_valid_a),
        .out_ready(out_ready), .imm_out(imm_a), .imm_fmt(fmt_a),
        .imm_illegal(illegal_a), .out_tag(tag_a), .illegal_cnt(cnt_a)
    );

    imm_gen_pipe #(.XLEN(64), .TAG_W(5), .CNT_W(16)) dut64 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_b),
        .inst_code(inst_code), .in_tag(in_tag), .out_valid(out_valid_b),
        .out_ready(out_ready), .imm_out(imm_b), .imm_fmt(fmt_b),
        .imm_illegal(illegal_b), .out_tag(tag_b), .illegal_cnt(cnt_b)
    );

    imm_gen_pipe #(.XLEN(32), .TAG_W(5), .CNT_W(2)) dutc (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_c),
        .inst_code(inst_code), .in_tag(in_tag), .out_valid(out_valid_c),
        .out_ready(out_ready), .imm_out(imm_c), .imm_fmt(fmt_c),
        .imm_illegal(illegal_c), .out_tag(tag_c), .illegal_cnt(cnt_c)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one instruction for a single cycle.
    task automatic send(input logic [31:0] inst, input logic [4:0] tag);
        in_valid  = 1'b1;
        inst_code = inst;
        in_tag    = tag;
        tick();
        in_valid  = 1'b0;
    endtask

    task automatic chk_out(input string name, input logic [31:0] imm, input logic [2:0] fmt,
                           input logic ill, input logic [4:0] tag);
        chk({name, ".valid"}, 64'(out_valid_a), 64'd1);
        chk({name, ".imm"}, 64'(imm_a), 64'(imm));
        chk({name, ".fmt"}, 64'(fmt_a), 64'(fmt));
        chk({name, ".illegal"}, 64'(illegal_a), 64'(ill));
        chk({name, ".tag"}, 64'(tag_a), 64'(tag));
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        inst_code = '0;
        in_tag    = '0;
        out_ready = 1'b1;
        tick();
        tick();
        chk("rst.in_ready_low", 64'(in_ready_a), 64'd0);
        chk("rst.out_valid", 64'(out_valid_a), 64'd0);
        reset = 1'b0;
        #1;
        chk("rst.in_ready_high", 64'(in_ready_a), 64'd1);
        chk("rst.imm", 64'(imm_a), 64'd0);
        chk("rst.fmt", 64'(fmt_a), 64'd0);
        chk("rst.illegal", 64'(illegal_a), 64'd0);
        chk("rst.tag", 64'(tag_a), 64'd0);
        chk("rst.cnt", 64'(cnt_a), 64'd0);

        // Back-to-back decode vectors at full throughput.
        send(32'hFFF00093, 5'd1);
        chk_out("addi", 32'hFFFFFFFF, 3'd1, 1'b0, 5'd1);
        send(32'hFE20AE23, 5'd2);
        chk_out("sw", 32'hFFFFFFFC, 3'd2, 1'b0, 5'd2);
        send(32'h123452B7, 5'd3);
        chk_out("lui", 32'h12345000, 3'd4, 1'b0, 5'd3);
        send(32'hFFDFF06F, 5'd4);
        chk_out("jal", 32'hFFFFFFFC, 3'd5, 1'b0, 5'd4);
        chk("jal.imm64", imm_b, 64'hFFFFFFFFFFFFFFFC);
        send(32'h01F09093, 5'd5);
        chk_out("slli31", 32'h0000001F, 3'd6, 1'b0, 5'd5);
        send(32'h4030D093, 5'd6);
        chk_out("srai3", 32'h00000003, 3'd6, 1'b0, 5'd6);
        send(32'hFE000CE3, 5'd7);
        chk_out("beq", 32'hFFFFFFF8, 3'd3, 1'b0, 5'd7);
        send(32'h002081B3, 5'd8);
        chk_out("add", 32'h00000000, 3'd0, 1'b0, 5'd8);
        send(32'h800002B7, 5'd9);
        chk("lui64.imm", imm_b, 64'hFFFFFFFF80000000);
        chk("lui64.fmt", 64'(fmt_b), 64'd4);
        send(32'h03F09093, 5'd10);
        chk("slli63.imm64", imm_b, 64'h000000000000003F);
        chk("slli63.imm32", 64'(imm_a), 64'h1F);
        tick();
        chk("drain.out_valid", 64'(out_valid_a), 64'd0);

        // Backpressure: A in main, B in skid, C stalled.
        out_ready = 1'b0;
        send(32'hFFF00093, 5'd11);
        chk("bp.A_in_ready", 64'(in_ready_a), 64'd1);
        chk("bp.A_tag", 64'(tag_a), 64'd11);
        send(32'h123452B7, 5'd12);
        chk("bp.B_in_ready", 64'(in_ready_a), 64'd0);
        chk("bp.B_hold_tag", 64'(tag_a), 64'd11);
        in_valid  = 1'b1;
        inst_code = 32'hFFDFF06F;
        in_tag    = 5'd13;
        tick();
        tick();
        chk("bp.C_stall_ready", 64'(in_ready_a), 64'd0);
        chk("bp.A_hold_imm", 64'(imm_a), 64'hFFFFFFFF);
        chk("bp.A_hold_tag", 64'(tag_a), 64'd11);
        out_ready = 1'b1;
        tick();
        chk("bp.B_tag", 64'(tag_a), 64'd12);
        chk("bp.B_imm", 64'(imm_a), 64'h12345000);
        chk("bp.ready_rise", 64'(in_ready_a), 64'd1);
        tick();
        in_valid = 1'b0;
        chk("bp.C_tag", 64'(tag_a), 64'd13);
        chk("bp.C_imm", 64'(imm_a), 64'hFFFFFFFC);
        tick();
        chk("bp.empty", 64'(out_valid_a), 64'd0);

        // Illegal instructions and counter saturation.
        send(32'h00000000, 5'd20);
        send(32'h00000000, 5'd21);
        send(32'h00000000, 5'd22);
        chk_out("illegal", 32'h0, 3'd7, 1'b1, 5'd22);
        tick();
        chk("cnt3", 64'(cnt_a), 64'd3);
        chk("cnt3.w2", 64'(cnt_c), 64'd3);
        send(32'h00000000, 5'd23);
        send(32'h00000000, 5'd24);
        tick();
        chk("cnt5", 64'(cnt_a), 64'd5);
        chk("cnt_sat.w2", 64'(cnt_c), 64'd3);

        // Reset with both entries full.
        out_ready = 1'b0;
        send(32'h00000000, 5'd25);
        send(32'h00000000, 5'd26);
        chk("full.in_ready", 64'(in_ready_a), 64'd0);
        reset = 1'b1;
        tick();
        chk("rst2.out_valid", 64'(out_valid_a), 64'd0);
        chk("rst2.cnt", 64'(cnt_a), 64'd0);
        chk("rst2.in_ready_low", 64'(in_ready_a), 64'd0);
        reset = 1'b0;
        #1;
        chk("rst2.in_ready_high", 64'(in_ready_a), 64'd1);
        chk("rst2.tag", 64'(tag_a), 64'd0);
        chk("rst2.illegal", 64'(illegal_a), 64'd0);
        tick();
        chk("rst2.still_empty", 64'(out_valid_a), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
